// File: rtl/apb_master.sv
// Single-outstanding APB requester: IDLE -> SETUP -> ACCESS -> RESP, all outputs registered.
// Optional ACCESS-phase abort on a stuck pready is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_pselx;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_to_cnt;
  logic       r_rsp_err;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_pselx     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_to_cnt    <= 8'd0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_pselx     <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          r_to_cnt  <= 8'd0;
`endif
        end
        S_ACCESS: begin
          if (pready) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_valid <= 1'b1;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            // This is the TIMEOUT-th stalled cycle: abort with an error response.
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_to_cnt    <= r_to_cnt + 8'd1;
`endif
          end
        end
        S_RESP: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, back-to-back, reset abort, idle pready.
// The timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pselx",     pselx,     0);
    chk("rst_penable",   penable,   0);
    chk("rst_pwrite",    pwrite,    0);
    chk("rst_paddr",     paddr,     0);
    chk("rst_pwdata",    pwdata,    0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err",   rsp_err,   0);
    step(); step();
    preset = 1'b0;
    step();
    chk("idle_ready", cmd_ready, 1);

    // Write with pready tied high
    pready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
    step();
    cmd_valid = 1'b0; cmd_wdata = 32'h0; cmd_write = 1'b0;
    chk("wr_setup_pselx",   pselx,     1);
    chk("wr_setup_penable", penable,   0);
    chk("wr_setup_paddr",   paddr,     32'h10);
    chk("wr_setup_pwrite",  pwrite,    1);
    chk("wr_setup_pwdata",  pwdata,    32'hDEADBEEF);
    chk("wr_setup_ready",   cmd_ready, 0);
    step();
    chk("wr_acc_penable", penable,   1);
    chk("wr_acc_pselx",   pselx,     1);
    chk("wr_acc_rvalid",  rsp_valid, 0);
    step();
    chk("wr_rsp_valid",   rsp_valid, 1);
    chk("wr_rsp_rdata",   rsp_rdata, 0);
    chk("wr_rsp_err",     rsp_err,   0);
    chk("wr_rsp_pselx",   pselx,     0);
    chk("wr_rsp_penable", penable,   0);
    chk("wr_rsp_ready",   cmd_ready, 0);
    step();
    chk("wr_idle_rvalid", rsp_valid, 0);
    chk("wr_idle_ready",  cmd_ready, 1);
    chk("wr_idle_paddr",  paddr,     32'h10);
    chk("wr_idle_pwrite", pwrite,    1);

    // Read with two wait states; garbage prdata while not ready
    pready = 1'b0; prdata = 32'h11111111;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    step();
    cmd_valid = 1'b0; cmd_addr = 32'h99;
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_pwrite",  pwrite,  0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_wait_penable", penable,   1);
      chk("rd_wait_paddr",   paddr,     32'h10);
      chk("rd_wait_rvalid",  rsp_valid, 0);
      if (i == 2) begin
        pready = 1'b1; prdata = 32'hDEADBEEF;
      end
    end
    step();
    chk("rd_rsp_valid",   rsp_valid, 1);
    chk("rd_rsp_rdata",   rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err",     rsp_err,   0);
    chk("rd_rsp_penable", penable,   0);
    step();
    chk("rd_hold_rvalid", rsp_valid, 0);
    chk("rd_hold_rdata",  rsp_rdata, 32'hDEADBEEF);

    // Back-to-back reads with cmd_valid held: accepts every 4th edge
    pready = 1'b1; prdata = 32'hCAFE0000; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd0;
    n_rsp = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (rsp_valid) n_rsp++;
      case (c % 4)
        0: begin
          chk("b2b_setup_paddr", paddr,     32'(c / 4));
          chk("b2b_setup_pen",   penable,   0);
          chk("b2b_setup_ready", cmd_ready, 0);
          cmd_addr = 32'(c / 4 + 1);
          if (c == 12) cmd_valid = 1'b0;
        end
        1: begin
          chk("b2b_acc_paddr", paddr,   32'(c / 4));
          chk("b2b_acc_pen",   penable, 1);
          prdata = 32'hCAFE0000 + 32'(c / 4);
        end
        2: begin
          chk("b2b_rsp_valid", rsp_valid, 1);
          chk("b2b_rsp_rdata", rsp_rdata, 32'hCAFE0000 + 32'(c / 4));
        end
        default: begin
          chk("b2b_idle_ready",  cmd_ready, 1);
          chk("b2b_idle_rvalid", rsp_valid, 0);
        end
      endcase
    end
    chk("b2b_rsp_count", n_rsp, 4);
    step();
    chk("b2b_done_pselx", pselx, 0);

    // Reset pulsed during ACCESS
    pready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rsta_acc_penable", penable, 1);
    #2;
    preset = 1'b1;
    #1;
    chk("rsta_async_pselx",   pselx,   0);
    chk("rsta_async_penable", penable, 0);
    chk("rsta_async_paddr",   paddr,   0);
    step();
    chk("rsta_no_rvalid", rsp_valid, 0);
    preset = 1'b0;
    chk("rsta_ready", cmd_ready, 1);
    step();
    chk("rsta_idle_rvalid", rsp_valid, 0);
    chk("rsta_idle_pselx",  pselx,     0);
    pready = 1'b1; prdata = 32'h12345678;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    step();
    cmd_valid = 1'b0;
    chk("rsta_rd_pselx", pselx, 1);
    chk("rsta_rd_paddr", paddr, 32'h20);
    step();
    step();
    chk("rsta_rd_rvalid", rsp_valid, 1);
    chk("rsta_rd_rdata",  rsp_rdata, 32'h12345678);
    step();

    // pready high while idle must not skip SETUP
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_prdy_pselx",  pselx,     0);
      chk("idle_prdy_rvalid", rsp_valid, 0);
    end
    prdata = 32'h0BADF00D; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
    step();
    cmd_valid = 1'b0;
    chk("prdy_setup_pselx",   pselx,     1);
    chk("prdy_setup_penable", penable,   0);
    chk("prdy_setup_rvalid",  rsp_valid, 0);
    step();
    chk("prdy_acc_penable", penable, 1);
    step();
    chk("prdy_rsp_valid", rsp_valid, 1);
    chk("prdy_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck pready: abort after 16 ACCESS cycles
    pready = 1'b0; prdata = 32'hFFFFFFFF; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    step();
    cmd_valid = 1'b0;
    chk("to_setup_penable", penable, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("to_wait_penable", penable,   1);
      chk("to_wait_rvalid",  rsp_valid, 0);
    end
    step();
    chk("to_rsp_valid",   rsp_valid, 1);
    chk("to_rsp_err",     rsp_err,   1);
    chk("to_rsp_rdata",   rsp_rdata, 0);
    chk("to_rsp_penable", penable,   0);
    step();
    pready = 1'b1; prdata = 32'h600DCAFE; cmd_valid = 1'b1; cmd_addr = 32'h54;
    step();
    cmd_valid = 1'b0;
    chk("to_next_paddr", paddr, 32'h54);
    step();
    step();
    chk("to_next_rvalid", rsp_valid, 1);
    chk("to_next_err",    rsp_err,   0);
    chk("to_next_rdata",  rsp_rdata, 32'h600DCAFE);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, width of cmd_addr and paddr.
REQ-002 SHALL provide parameter DATA_W, default 32, width of all data buses.
REQ-003 SHALL provide parameter TIMEOUT, default 16, maximum ACCESS cycles with pready low before abort (legal range 1..255).
REQ-004 pclk  input  1  single clock; all logic on rising edge.
REQ-005 preset  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  transfer request present.
REQ-007 cmd_ready  output  1  block can accept a request this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  transfer aborted by timeout; valid with rsp_valid.
REQ-014 pselx  output  1  APB select to the peripheral.
REQ-015 penable  output  1  APB enable.
REQ-016 pwrite  output  1  APB direction.
REQ-017 paddr  output  ADDR_W  APB address.
REQ-018 pwdata  output  DATA_W  APB write data.
REQ-019 pready  input  1  peripheral completion.
REQ-020 prdata  input  DATA_W  peripheral read data.

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-022 IDLE: cmd_ready=1, pselx=0, penable=0; on cmd_valid=1, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
REQ-023 SETUP (exactly one cycle): pselx=1, penable=0, cmd_ready=0; next state ACCESS.
REQ-024 ACCESS: pselx=1, penable=1; stay while pready=0; on pready=1 go to RESP.
REQ-025 pready SHALL be ignored in IDLE, SETUP and RESP (peripheral may hold pready high between transfers).
REQ-026 On pready=1 in ACCESS: rsp_rdata <= prdata if pwrite=0, else 0; rsp_err <= 0.
REQ-027 RESP (exactly one cycle): rsp_valid=1, pselx=0, penable=0, cmd_ready=0; next state IDLE.
REQ-028 rsp_valid SHALL be 0 in all other states; rsp_rdata/rsp_err hold last value until next completion.
REQ-029 pwrite/paddr/pwdata SHALL stay constant from SETUP through the end of ACCESS and hold last value in IDLE/RESP.
REQ-030 Minimum transfer latency: accept edge to rsp_valid = 3 cycles with pready=1 in first ACCESS cycle; back-to-back throughput one transfer per 4 cycles.
REQ-031 cmd_* inputs SHALL be ignored when cmd_ready=0; no queueing.

Reset
REQ-032 preset=1 SHALL immediately force state IDLE, pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
REQ-033 Reset during SETUP/ACCESS/RESP SHALL abandon the transfer with no rsp_valid pulse; cmd_ready=1 in first cycle after deassertion.

Configuration
REQ-034 Macro APB_MASTER_TIMEOUT_EN defined: 8-bit counter clears on SETUP, increments each ACCESS cycle with pready=0; when count reaches TIMEOUT, go to RESP with rsp_err=1, rsp_rdata=0.
REQ-035 Macro undefined: no counter; ACCESS waits indefinitely for pready; rsp_err constant 0.

Verification
REQ-036 Write, pready tied 1: cmd addr=0x10 wdata=0xDEADBEEF -> SETUP next cycle with paddr=0x10, pwrite=1; penable 1 cycle later; rsp_valid 3 cycles after accept, rsp_rdata=0, rsp_err=0.
REQ-037 Read after write, peripheral returns prdata=0xDEADBEEF with 2 wait states -> penable high 3 cycles, rsp_rdata=0xDEADBEEF, paddr stable throughout.
REQ-038 cmd_valid held high with 4 queued addresses 0..3 -> exactly 4 rsp_valid pulses, 4 cycles apart, cmd_ready low between accepts.
REQ-039 Timeout, APB_MASTER_TIMEOUT_EN, TIMEOUT=16, pready stuck 0 -> penable high 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; next command accepted normally.
REQ-040 preset pulsed during ACCESS -> pselx/penable drop asynchronously to 0, no rsp_valid, new read to 0x20 completes correctly afterwards.
REQ-041 pready held 1 while IDLE, then read issued -> block still passes through SETUP (penable=0 one cycle) before completing.
